// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Ports: flush, req, gnt_ready driven by the requester side (master);
//        gnt_valid, gnt_onehot, gnt_idx, ptr driven by the arbiter (slave).
interface rr_arbiter_if #(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
);
  logic             flush;
  logic [N-1:0]     req;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr;

  // Requester / consumer side.
  modport master (
    output flush,
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_onehot,
    input  gnt_idx,
    input  ptr
  );

  // Arbiter side.
  modport slave (
    input  flush,
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_onehot,
    output gnt_idx,
    output ptr
  );
endinterface

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: one sticky grant, rotating priority pointer.
// Latency: req sampled at a posedge is presented as a grant after that edge;
//          no combinational path from req to any output.
// Backpressure: a presented grant is held unchanged until gnt_ready; an
//          accept may present the next grant from the same edge.
// Ports: clock, reset (async active-low), bus (rr_arbiter_if.slave) carrying
//        flush/req/gnt_ready in and gnt_valid/gnt_onehot/gnt_idx/ptr out.
// N must be a power of two (>= 2): pointer and index arithmetic rely on
// natural IDX_W-bit wrap-around for the modulo-N step.
module rr_arbiter #(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic       clock,
  input  logic       reset,
  rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic             valid_q;
  logic [N-1:0]     onehot_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;

  // Search start for the next grant. In GRANT the candidate search already
  // starts just past the current winner, so the same combinational result
  // serves a back-to-back grant on accept.
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] pos;
  logic [IDX_W-1:0] sel_idx;
  logic             found;

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Circular ascending search from base. Walking the offsets from the far
  // end down to zero lets the nearest active requester overwrite any
  // farther one, which gives first-at-or-after-base priority.
  always_comb begin
    base    = (state == GRANT) ? idx_q + IDX_W'(1) : ptr_q;
    found   = 1'b0;
    sel_idx = '0;
    pos     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = base + IDX_W'(i);
      if (bus.req[pos]) begin
        found   = 1'b1;
        sel_idx = pos;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else if (bus.flush) begin
      // Flush squashes the grant and discards a coincident accept.
      state    <= IDLE;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            valid_q  <= 1'b1;
            onehot_q <= to_onehot(sel_idx);
            idx_q    <= sel_idx;
          end
        end
        GRANT: begin
          // Without gnt_ready the grant is sticky regardless of req.
          if (bus.gnt_ready) begin
            ptr_q <= base;
            if (found) begin
              onehot_q <= to_onehot(sel_idx);
              idx_q    <= sel_idx;
            end else begin
              state    <= IDLE;
              valid_q  <= 1'b0;
              onehot_q <= '0;
              idx_q    <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          valid_q  <= 1'b0;
          onehot_q <= '0;
          idx_q    <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.ptr        = ptr_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a grant/pointer model built from the
// selection rule sel(r, p).
module tb_rr_arbiter;
  localparam int N     = 32;
  localparam int IDX_W = $clog2(N);

  logic clock;
  logic reset;

  rr_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // First index at or after p (circularly) with a set request, -1 if none.
  function automatic int sel(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int s;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else begin
      s = -2;  // -2: nothing happens this edge
      if (m_valid == 0) begin
        s = sel(bus.req, m_ptr);
      end else if (bus.gnt_ready) begin
        m_ptr = (m_idx + 1) % N;
        s = sel(bus.req, m_ptr);
      end
      if (s >= 0) begin
        m_valid = 1; m_idx = s;
      end else if (s == -1) begin
        m_valid = 0; m_idx = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic             hold_pending = 1'b0;
  logic [IDX_W-1:0] prev_idx     = '0;
  logic [N-1:0]     prev_onehot  = '0;
  logic [N-1:0]     exp_oh;

  always @(negedge clock) begin
    exp_oh = '0;
    if (m_valid != 0) exp_oh[m_idx] = 1'b1;
    check("cyc_valid",  bus.gnt_valid, m_valid);
    check("cyc_idx",    bus.gnt_idx, (m_valid != 0) ? m_idx : 0);
    check("cyc_onehot", bus.gnt_onehot, exp_oh);
    check("cyc_ptr",    bus.ptr, m_ptr);
    if (bus.gnt_valid) begin
      check("inv_onehot",   $onehot(bus.gnt_onehot), 1);
      check("inv_bit_at_idx", bus.gnt_onehot[bus.gnt_idx], 1);
    end else begin
      check("inv_zero_onehot", bus.gnt_onehot, 0);
    end
    if (hold_pending && reset) begin
      check("hold_idx",    bus.gnt_idx, prev_idx);
      check("hold_onehot", bus.gnt_onehot, prev_onehot);
    end
    // gnt_ready/flush seen now are what the next posedge samples.
    hold_pending = bus.gnt_valid && !bus.gnt_ready && !bus.flush && reset;
    prev_idx     = bus.gnt_idx;
    prev_onehot  = bus.gnt_onehot;
  end

  // Drop the hold check if reset pulses between two compare points.
  always @(negedge reset) hold_pending = 1'b0;

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_flush();
    bus.flush     = 1'b1;
    bus.gnt_ready = 1'b0;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.req       = '1;
    bus.gnt_ready = 1'b0;

    // Reset with all requests high, release between edges.
    #12;
    check("rst_valid", bus.gnt_valid, 0);
    check("rst_ptr",   bus.ptr, 0);
    reset = 1'b1;
    #1;
    check("rel_valid", bus.gnt_valid, 0);
    check("rel_ptr",   bus.ptr, 0);
    step();
    check("first_idx",    bus.gnt_idx, 0);
    check("first_onehot", bus.gnt_onehot, 32'h0000_0001);
    check("first_valid",  bus.gnt_valid, 1);

    // Back-to-back with two requesters.
    do_flush();
    check("b2b_flush_valid", bus.gnt_valid, 0);
    bus.req       = 32'h0000_0011;
    bus.gnt_ready = 1'b1;
    step();
    check("b2b_idx0", bus.gnt_idx, 0);
    check("b2b_ptr0", bus.ptr, 0);
    step();
    check("b2b_idx1", bus.gnt_idx, 4);
    check("b2b_ptr1", bus.ptr, 1);
    step();
    check("b2b_idx2", bus.gnt_idx, 0);
    check("b2b_ptr2", bus.ptr, 5);
    step();
    check("b2b_idx3", bus.gnt_idx, 4);
    check("b2b_ptr3", bus.ptr, 1);
    bus.gnt_ready = 1'b0;
    bus.req       = '0;

    // Wrap-around at N-1.
    do_flush();
    bus.req = 32'h4000_0000;
    step();
    check("wrap_pre_idx", bus.gnt_idx, 30);
    bus.req       = 32'h8000_0001;
    bus.gnt_ready = 1'b1;
    step();
    check("wrap_idx31", bus.gnt_idx, 31);
    check("wrap_ptr31", bus.ptr, 31);
    step();
    check("wrap_idx0", bus.gnt_idx, 0);
    check("wrap_ptr0", bus.ptr, 0);
    step();
    check("wrap_ptr1", bus.ptr, 1);
    check("wrap_idx_after", bus.gnt_idx, 31);
    bus.gnt_ready = 1'b0;
    bus.req       = '0;

    // Sticky grant while the requester withdraws.
    do_flush();
    bus.req = 32'h0000_0080;
    step();
    check("hold_start_idx", bus.gnt_idx, 7);
    bus.req = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("hold_cyc_idx",    bus.gnt_idx, 7);
      check("hold_cyc_onehot", bus.gnt_onehot, 32'h0000_0080);
    end
    bus.gnt_ready = 1'b1;
    step();
    check("hold_acc_valid", bus.gnt_valid, 0);
    check("hold_acc_ptr",   bus.ptr, 8);
    check("hold_acc_idx",   bus.gnt_idx, 0);

    // Flush coinciding with accept.
    do_flush();
    bus.req = 32'h0000_1000;
    step();
    check("fc_pre_idx", bus.gnt_idx, 12);
    bus.flush     = 1'b1;
    bus.gnt_ready = 1'b1;
    step();
    check("fc_valid", bus.gnt_valid, 0);
    check("fc_ptr",   bus.ptr, 0);
    bus.flush     = 1'b0;
    bus.gnt_ready = 1'b0;
    step();
    check("fc_regrant_idx",   bus.gnt_idx, 12);
    check("fc_regrant_valid", bus.gnt_valid, 1);
    check("fc_regrant_ptr",   bus.ptr, 0);

    // Asynchronous reset in the middle of a grant.
    do_flush();
    bus.req = 32'h0000_0008;
    step();
    check("ar_pre_idx", bus.gnt_idx, 3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid",  bus.gnt_valid, 0);
    check("ar_idx",    bus.gnt_idx, 0);
    check("ar_onehot", bus.gnt_onehot, 0);
    check("ar_ptr",    bus.ptr, 0);
    step();
    bus.req = '0;
    reset   = 1'b1;
    step();
    check("ar_after_valid", bus.gnt_valid, 0);
    check("ar_after_ptr",   bus.ptr, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
